// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyphs (abcdefg, bit6=a), blank/invalid codes, reader FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_GLYPH_0 = 7'b0000001;
  localparam logic [6:0] SEG_GLYPH_1 = 7'b1001111;
  localparam logic [6:0] SEG_GLYPH_2 = 7'b0010010;
  localparam logic [6:0] SEG_GLYPH_3 = 7'b0000110;
  localparam logic [6:0] SEG_GLYPH_4 = 7'b1001100;
  localparam logic [6:0] SEG_GLYPH_5 = 7'b0100100;
  localparam logic [6:0] SEG_GLYPH_6 = 7'b0100000;
  localparam logic [6:0] SEG_GLYPH_7 = 7'b0001111;
  localparam logic [6:0] SEG_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG_GLYPH_9 = 7'b0000100;

  localparam logic [6:0] SEG_BLANK_N   = 7'h7F;
  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_COMPLETE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the display encoder: active-low glyph -> digit value, err on any non-digit pattern.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] value_o,
  output logic       err_o
);

  always_comb begin
    value_o = DIGIT_INVALID;
    err_o   = 1'b0;
    case (seg_n_i)
      SEG_GLYPH_0: value_o = 4'd0;
      SEG_GLYPH_1: value_o = 4'd1;
      SEG_GLYPH_2: value_o = 4'd2;
      SEG_GLYPH_3: value_o = 4'd3;
      SEG_GLYPH_4: value_o = 4'd4;
      SEG_GLYPH_5: value_o = 4'd5;
      SEG_GLYPH_6: value_o = 4'd6;
      SEG_GLYPH_7: value_o = 4'd7;
      SEG_GLYPH_8: value_o = 4'd8;
      SEG_GLYPH_9: value_o = 4'd9;
      default:     err_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Readback monitor for a multiplexed 7-segment bus: debounces each digit, decodes it and
// assembles a full frame that leaves on a valid/ready handshake.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overflow,
  output logic                    timeout
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  scan_state_e state_q, state_d;

  logic [6:0]              seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   den_q;
  logic [IW-1:0]           prev_idx_q;
  logic                    prev_act_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] stg_data_q, stg_data_d, data_q, data_d;
  logic [NUM_DIGITS-1:0]   stg_err_q, stg_err_d, err_q, err_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic                    valid_q, valid_d, ovf_q, ovf_d, tmo_q, tmo_d;

  logic [3:0]            n_low;
  logic [IW-1:0]         idx;
  logic                  act, same, cap, mask_full, to_hit;
  logic [NUM_DIGITS-1:0] cap_bit;
  logic [3:0]            dec_val;
  logic                  dec_err;
  logic                  transfer, tmo_fire, mask_clr, to_run, accept;

  seg7_glyph_decode u_decode (
    .seg_n_i (seg_q),
    .value_o (dec_val),
    .err_o   (dec_err)
  );

  // Exactly one low enable selects a digit; anything else is treated as blanking.
  always_comb begin
    n_low = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!den_q[i]) begin
        n_low = n_low + 4'd1;
        idx   = IW'(i);
      end
    end
    act = (n_low == 4'd1);
  end

  always_comb begin
    same = act && prev_act_q && (idx == prev_idx_q) && (seg_q == prev_seg_q);
    cap  = same && (cnt_q == CW'(STABLE_CYCLES - 1));
    if (!act)
      cnt_d = '0;
    else if (!same)
      cnt_d = CW'(1);
    else if (cnt_q == CW'(STABLE_CYCLES))
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CW'(1);
    cap_bit = '0;
    if (cap)
      cap_bit[idx] = 1'b1;
    mask_full = ((mask_q | cap_bit) == {NUM_DIGITS{1'b1}});
    to_hit    = (to_cnt_q == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (cap) state_d = mask_full ? ST_COMPLETE : ST_COLLECT;
      ST_COLLECT: begin
        if (cap && mask_full)
          state_d = ST_COMPLETE;
        else if (to_hit)
          state_d = ST_IDLE;
      end
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    transfer = (state_q == ST_COMPLETE);
    to_run   = (state_q == ST_COLLECT);
    tmo_fire = to_run && to_hit && !(cap && mask_full);
    mask_clr = transfer || tmo_fire;
  end

  // Transfer uses the staging next-state so a capture landing in COMPLETE is not lost.
  always_comb begin
    stg_data_d = stg_data_q;
    stg_err_d  = stg_err_q;
    if (cap) begin
      stg_data_d[4*idx +: 4] = dec_val;
      stg_err_d[idx]         = dec_err;
    end
    mask_d   = mask_clr ? '0 : (mask_q | cap_bit);
    to_cnt_d = (to_run && state_d == ST_COLLECT) ? to_cnt_q + TW'(1) : '0;
    tmo_d    = tmo_fire;
    accept   = valid_q && frame_ready;
    data_d   = data_q;
    err_d    = err_q;
    valid_d  = valid_q && !accept;
    ovf_d    = ovf_q;
    if (transfer) begin
      if (!valid_q || accept) begin
        data_d  = stg_data_d;
        err_d   = stg_err_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= SEG_BLANK_N;
      den_q      <= '1;
      prev_seg_q <= SEG_BLANK_N;
      prev_idx_q <= '0;
      prev_act_q <= 1'b0;
      cnt_q      <= '0;
      mask_q     <= '0;
      stg_data_q <= '0;
      stg_err_q  <= '0;
      to_cnt_q   <= '0;
      data_q     <= '0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      seg_q      <= seg_n;
      den_q      <= dig_en_n;
      prev_seg_q <= seg_q;
      prev_idx_q <= idx;
      prev_act_q <= act;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      stg_data_q <= stg_data_d;
      stg_err_q  <= stg_err_d;
      to_cnt_q   <= to_cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_err   = err_q;
  assign frame_valid = valid_q;
  assign overflow    = ovf_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: expected frames are queued as digits are scanned and checked on delivery.
module tb_seg7_scan_reader;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_n;
  logic [N-1:0]  dig_en_n;
  logic [4*N-1:0] frame_data;
  logic [N-1:0]  frame_err;
  logic          frame_valid;
  logic          frame_ready;
  logic          overflow;
  logic          timeout;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  err;
  } frame_t;
  frame_t exp_q[$];

  logic [6:0] glyph_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seg7_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(8), .TIMEOUT(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dig_en_n    (dig_en_n),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (glyph_tab[i] == p) return {1'b0, 4'(i)};
    return {1'b1, 4'hF};
  endfunction

  task automatic push_expected(input logic [27:0] pats);
    frame_t f;
    logic [4:0] r;
    f = '0;
    for (int d = 0; d < N; d++) begin
      r = model_decode(pats[7*d +: 7]);
      f.data[4*d +: 4] = r[3:0];
      f.err[d]         = r[4];
    end
    exp_q.push_back(f);
  endtask

  task automatic scan_frame(input logic [27:0] pats, input int ndig);
    for (int d = 0; d < ndig; d++) begin
      dig_en_n = ~(4'b0001 << d);
      seg_n    = pats[7*d +: 7];
      repeat (10) @(negedge clk);
    end
    dig_en_n = '1;
    seg_n    = 7'h7F;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; seg_n = 7'h7F; dig_en_n = '1; frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    tests++; if (frame_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", frame_data); end
    tests++; if (frame_err !== 4'h0) begin fails++; $display("FAIL reset_err got %b want 0000", frame_err); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", timeout); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %b want 0", frame_valid); end
  endtask

  // Scan, wait, pop/compare, then single-cycle accept; shared by the frame-producing scenarios below.
  task automatic test_frame(input string name, input logic [27:0] pats);
    bit ok;
    frame_t e;
    push_expected(pats);
    scan_frame(pats, N);
    wait_valid(40, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL %s_valid got 0 want 1 within 40 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      tests++; if (frame_data !== e.data) begin fails++; $display("FAIL %s_data got %h want %h", name, frame_data, e.data); end
      tests++; if (frame_err !== e.err) begin fails++; $display("FAIL %s_err got %b want %b", name, frame_err, e.err); end
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL %s_valid_fall got %b want 0", name, frame_valid); end
  endtask

  task automatic test_basic;
    test_frame("basic", {7'b0000100, 7'b0000110, 7'b1001111, 7'b0010010});
  endtask

  task automatic test_bad_glyph;
    test_frame("bad_glyph", {7'b0001111, 7'b1111110, 7'b0100100, 7'b0000001});
  endtask

  task automatic test_back_to_back;
    test_frame("b2b_a", {7'b0000000, 7'b0100000, 7'b1001100, 7'b1001111});
    test_frame("b2b_b", {7'b1001111, 7'b1100000, 7'b0000110, 7'b0000100});
  endtask

  task automatic test_two_active;
    logic [27:0] pats;
    bit seen;
    bit ok;
    frame_t e;
    pats = {7'b0100100, 7'b0000110, 7'b1001111, 7'b0010010};
    push_expected(pats);
    scan_frame(pats, 2);
    dig_en_n = 4'b1100;
    seg_n    = 7'b0000000;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (frame_valid !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL two_active_valid got 1 want 0"); end
    for (int d = 2; d < N; d++) begin
      dig_en_n = ~(4'b0001 << d);
      seg_n    = pats[7*d +: 7];
      repeat (10) @(negedge clk);
    end
    dig_en_n = '1; seg_n = 7'h7F;
    wait_valid(40, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL two_active_frame got valid 0 want 1");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      tests++; if (frame_data !== e.data) begin fails++; $display("FAIL two_active_data got %h want %h", frame_data, e.data); end
    end
    frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [27:0] pa, pb;
    bit ok;
    frame_t e;
    pa = {7'b0000001, 7'b0000100, 7'b0000000, 7'b0001111};
    pb = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_pre got %b want 0", overflow); end
    push_expected(pa);
    scan_frame(pa, N);
    wait_valid(40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_first_valid got 0 want 1"); end
    scan_frame(pb, N);
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL ovf_held_valid got %b want 1", frame_valid); end
    tests++; if (frame_data !== e.data) begin fails++; $display("FAIL ovf_held_data got %h want %h", frame_data, e.data); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
    frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL ovf_accept_fall got %b want 0", frame_valid); end
    repeat (3) @(negedge clk);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid;
    scan_frame({7'b0000001, 7'b0000100, 7'b0000000, 7'b0001111}, 3);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", frame_valid); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    tests++; if (frame_data !== 16'h0) begin fails++; $display("FAIL rstmid_data got %h want 0000", frame_data); end
    rst = 1'b0;
    @(negedge clk);
    test_frame("post_rst", {7'b0100000, 7'b0100100, 7'b1001100, 7'b0000110});
  endtask

  task automatic test_timeout;
    bit vseen;
    bit hit;
    int k_hit;
    vseen = 1'b0; hit = 1'b0; k_hit = -1;
    dig_en_n = 4'b1110; seg_n = 7'b0010010;
    repeat (10) @(negedge clk);
    dig_en_n = 4'b1101;
    for (int k = 0; k < 5000; k++) begin
      if (k % 5 == 0) seg_n = ((k / 5) % 2 == 0) ? 7'b1001100 : 7'b0100100;
      @(negedge clk);
      if (frame_valid !== 1'b0) vseen = 1'b1;
      if (timeout === 1'b1) begin
        hit = 1'b1; k_hit = k;
        break;
      end
    end
    tests++; if (!hit) begin fails++; $display("FAIL timeout_pulse got none want pulse within 5000 cycles"); end
    tests++; if (k_hit < 4090 || k_hit > 4100) begin fails++; $display("FAIL timeout_time got %0d want 4090..4100", k_hit); end
    @(negedge clk);
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_width got %b want 0", timeout); end
    tests++; if (vseen) begin fails++; $display("FAIL timeout_novalid got 1 want 0"); end
    dig_en_n = '1; seg_n = 7'h7F;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_glyph();
    test_back_to_back();
    test_two_active();
    test_overflow();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
